// File: rtl/tcp_conn_table_if.sv
// Bus bundle between the connection table and its RX/TX/application neighbours.
interface tcp_conn_table_if #(
    parameter int unsigned NUM_SOCK = 4,
    parameter int unsigned ID_W     = $clog2(NUM_SOCK)
);
    logic                init_v_i;
    logic [31:0]         init_seq_i;
    logic                init_ready_o;
    logic [ID_W-1:0]     init_id_o;
    logic                close_v_i;
    logic [ID_W-1:0]     close_id_i;
    logic                cancel_v_i;
    logic [ID_W-1:0]     cancel_id_i;
    logic                rec_v_i;
    logic [ID_W-1:0]     rec_id_i;
    logic [15:0]         rec_size_i;
    logic [31:0]         rec_seq_i;
    logic [31:0]         rec_ack_i;
    logic [7:0]          rec_flag_i;
    logic                data_v_i;
    logic [ID_W-1:0]     data_id_i;
    logic [15:0]         data_size_i;
    logic                req_v_o;
    logic                req_ready_i;
    logic [ID_W-1:0]     req_id_o;
    logic [7:0]          req_flag_o;
    logic [31:0]         req_seq_o;
    logic [31:0]         req_ack_o;
    logic [NUM_SOCK-1:0] valid_o;
    logic [NUM_SOCK-1:0] est_o;

    modport master (
        output init_v_i, init_seq_i, close_v_i, close_id_i, cancel_v_i, cancel_id_i,
               rec_v_i, rec_id_i, rec_size_i, rec_seq_i, rec_ack_i, rec_flag_i,
               data_v_i, data_id_i, data_size_i, req_ready_i,
        input  init_ready_o, init_id_o, req_v_o, req_id_o, req_flag_o, req_seq_o,
               req_ack_o, valid_o, est_o
    );

    modport slave (
        input  init_v_i, init_seq_i, close_v_i, close_id_i, cancel_v_i, cancel_id_i,
               rec_v_i, rec_id_i, rec_size_i, rec_seq_i, rec_ack_i, rec_flag_i,
               data_v_i, data_id_i, data_size_i, req_ready_i,
        output init_ready_o, init_id_o, req_v_o, req_id_o, req_flag_o, req_seq_o,
               req_ack_o, valid_o, est_o
    );
endinterface

// File: rtl/tcp_conn_table.sv
// Multi-socket TCP connection table: per-socket open/close lifetime, seq/ack
// tracking, delayed ACK, TIME_WAIT timeout and round-robin control-packet arbiter.
module tcp_conn_table #(
    parameter int unsigned NUM_SOCK  = 4,
    parameter int unsigned ID_W      = $clog2(NUM_SOCK),
    parameter int unsigned TW_CYCLES = 1024
) (
    input  logic            clk,
    input  logic            nreset,
    tcp_conn_table_if.slave bus
);
    localparam int unsigned CNT_W    = $clog2(TW_CYCLES + 1);
    localparam logic [7:0]  FLAG_ACK = 8'h08;
    localparam logic [7:0]  FLAG_SYN = 8'h40;
    localparam logic [7:0]  FLAG_FIN = 8'h80;

    typedef enum logic [9:0] {
        CLOSED      = 10'b00_0000_0001,
        SYN_EMIT    = 10'b00_0000_0010,
        SYN_SENT    = 10'b00_0000_0100,
        ACK_EMIT    = 10'b00_0000_1000,
        ESTABLISHED = 10'b00_0001_0000,
        FIN1_EMIT   = 10'b00_0010_0000,
        FIN_WAIT_1  = 10'b00_0100_0000,
        FIN_WAIT_2  = 10'b00_1000_0000,
        TW_EMIT     = 10'b01_0000_0000,
        TIME_WAIT   = 10'b10_0000_0000
    } state_t;

    state_t              state_q [NUM_SOCK];
    state_t              state_d [NUM_SOCK];
    logic [31:0]         seq_q   [NUM_SOCK];
    logic [31:0]         seq_d   [NUM_SOCK];
    logic [31:0]         ack_q   [NUM_SOCK];
    logic [31:0]         ack_d   [NUM_SOCK];
    logic [CNT_W-1:0]    cnt_q   [NUM_SOCK];
    logic [CNT_W-1:0]    cnt_d   [NUM_SOCK];
    logic [NUM_SOCK-1:0] pend_q, pend_d;

    logic [ID_W-1:0]     ptr_q;
    logic                lock_v_q;
    logic [ID_W-1:0]     lock_id_q;

    logic [NUM_SOCK-1:0] closed_vec, est_vec, req_vec;
    logic [NUM_SOCK-1:0] hit_cancel, hit_close, hit_rec, hit_data, hit_grant, hit_alloc;
    logic                init_ready;
    logic [ID_W-1:0]     free_id;
    logic                sel_v;
    logic [ID_W-1:0]     sel_id;
    logic [ID_W-1:0]     idx;
    int unsigned         idx_w;
    logic [7:0]          sel_flag;
    logic                grant;
    logic                unused_bits;

    // Per-entry status vectors derived from registered state
    always_comb begin
        closed_vec = '0;
        est_vec    = '0;
        req_vec    = '0;
        for (int unsigned i = 0; i < NUM_SOCK; i++) begin
            closed_vec[i] = (state_q[i] == CLOSED);
            est_vec[i]    = (state_q[i] == ESTABLISHED);
            req_vec[i]    = (state_q[i] == SYN_EMIT) || (state_q[i] == ACK_EMIT) ||
                            (state_q[i] == FIN1_EMIT) || (state_q[i] == TW_EMIT) ||
                            ((state_q[i] == ESTABLISHED) && pend_q[i]);
        end
    end

    // Allocation picks the lowest-index CLOSED entry
    always_comb begin
        free_id = '0;
        for (int i = int'(NUM_SOCK) - 1; i >= 0; i--) begin
            if (closed_vec[i]) begin
                free_id = ID_W'(i);
            end
        end
    end

    assign init_ready = |closed_vec;

    // Arbiter: keep an ungranted selection, otherwise search from the entry after the last grant
    always_comb begin
        sel_v  = 1'b0;
        sel_id = '0;
        idx    = '0;
        idx_w  = 0;
        if (lock_v_q && req_vec[lock_id_q]) begin
            sel_v  = 1'b1;
            sel_id = lock_id_q;
        end else begin
            for (int unsigned k = 1; k <= NUM_SOCK; k++) begin
                idx_w = (32'(ptr_q) + k) % NUM_SOCK;
                idx   = ID_W'(idx_w);
                if (!sel_v && req_vec[idx]) begin
                    sel_v  = 1'b1;
                    sel_id = idx;
                end
            end
        end
    end

    // Control flags for the selected entry
    always_comb begin
        sel_flag = 8'h00;
        if (sel_v) begin
            case (state_q[sel_id])
                SYN_EMIT:  sel_flag = FLAG_SYN;
                FIN1_EMIT: sel_flag = FLAG_FIN | FLAG_ACK;
                default:   sel_flag = FLAG_ACK;
            endcase
        end
    end

    assign grant = sel_v && bus.req_ready_i;

    // Decode which events target each entry this cycle
    always_comb begin
        hit_cancel = '0;
        hit_close  = '0;
        hit_rec    = '0;
        hit_data   = '0;
        hit_grant  = '0;
        hit_alloc  = '0;
        for (int unsigned i = 0; i < NUM_SOCK; i++) begin
            hit_cancel[i] = bus.cancel_v_i && (bus.cancel_id_i == ID_W'(i));
            hit_close[i]  = bus.close_v_i && (bus.close_id_i == ID_W'(i));
            hit_rec[i]    = bus.rec_v_i && (bus.rec_id_i == ID_W'(i));
            hit_data[i]   = bus.data_v_i && (bus.data_id_i == ID_W'(i));
            hit_grant[i]  = grant && (sel_id == ID_W'(i));
            hit_alloc[i]  = bus.init_v_i && init_ready && (free_id == ID_W'(i));
        end
    end

    // Per-entry next-state, sequence and acknowledgement logic; cancel wins over everything
    always_comb begin
        pend_d = pend_q;
        for (int unsigned i = 0; i < NUM_SOCK; i++) begin
            state_d[i] = state_q[i];
            seq_d[i]   = seq_q[i];
            ack_d[i]   = ack_q[i];
            cnt_d[i]   = cnt_q[i];
            if (hit_cancel[i]) begin
                state_d[i] = CLOSED;
                pend_d[i]  = 1'b0;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    CLOSED: begin
                        if (hit_alloc[i]) begin
                            state_d[i] = SYN_EMIT;
                            seq_d[i]   = bus.init_seq_i;
                            ack_d[i]   = 32'd0;
                            pend_d[i]  = 1'b0;
                        end
                    end
                    SYN_EMIT: begin
                        if (hit_grant[i]) begin
                            state_d[i] = SYN_SENT;
                            seq_d[i]   = seq_q[i] + 32'd1;
                        end
                    end
                    SYN_SENT: begin
                        if (hit_rec[i] && bus.rec_flag_i[6] && bus.rec_flag_i[3]) begin
                            state_d[i] = ACK_EMIT;
                            ack_d[i]   = bus.rec_seq_i + 32'd1;
                        end
                    end
                    ACK_EMIT: begin
                        if (hit_grant[i]) begin
                            state_d[i] = ESTABLISHED;
                        end
                    end
                    ESTABLISHED: begin
                        if (hit_rec[i]) begin
                            ack_d[i] = ack_q[i] + 32'(bus.rec_size_i);
                        end
                        if (hit_data[i]) begin
                            seq_d[i] = seq_q[i] + 32'(bus.data_size_i);
                        end
                        if (hit_data[i] || hit_grant[i]) begin
                            pend_d[i] = 1'b0;
                        end
                        if (hit_rec[i] && (bus.rec_size_i != 16'd0)) begin
                            pend_d[i] = 1'b1;
                        end
                        if (hit_close[i]) begin
                            state_d[i] = FIN1_EMIT;
                        end
                    end
                    FIN1_EMIT: begin
                        if (hit_grant[i]) begin
                            state_d[i] = FIN_WAIT_1;
                            seq_d[i]   = seq_q[i] + 32'd1;
                        end
                    end
                    FIN_WAIT_1: begin
                        if (hit_rec[i] && bus.rec_flag_i[3]) begin
                            state_d[i] = FIN_WAIT_2;
                        end
                    end
                    FIN_WAIT_2: begin
                        if (hit_rec[i] && bus.rec_flag_i[7]) begin
                            state_d[i] = TW_EMIT;
                            ack_d[i]   = bus.rec_seq_i + 32'(bus.rec_size_i) + 32'd1;
                        end
                    end
                    TW_EMIT: begin
                        if (hit_grant[i]) begin
                            state_d[i] = TIME_WAIT;
                            cnt_d[i]   = CNT_W'(TW_CYCLES);
                        end
                    end
                    TIME_WAIT: begin
                        if (cnt_q[i] <= CNT_W'(1)) begin
                            state_d[i] = CLOSED;
                            cnt_d[i]   = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] - CNT_W'(1);
                        end
                    end
                    default: begin
                        state_d[i] = CLOSED;
                    end
                endcase
            end
        end
    end

    // Lifetime state, counters, delayed-ACK flags and arbiter registers
    always_ff @(posedge clk) begin
        if (!nreset) begin
            for (int unsigned i = 0; i < NUM_SOCK; i++) begin
                state_q[i] <= CLOSED;
                cnt_q[i]   <= '0;
            end
            pend_q    <= '0;
            ptr_q     <= ID_W'(NUM_SOCK - 1);
            lock_v_q  <= 1'b0;
            lock_id_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_SOCK; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            pend_q    <= pend_d;
            if (grant) begin
                ptr_q <= sel_id;
            end
            lock_v_q  <= sel_v && !bus.req_ready_i;
            lock_id_q <= sel_id;
        end
    end

    // Sequence/ack numbers are only meaningful once loaded by allocation
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_SOCK; i++) begin
            seq_q[i] <= seq_d[i];
            ack_q[i] <= ack_d[i];
        end
    end

    assign bus.init_ready_o = init_ready;
    assign bus.init_id_o    = free_id;
    assign bus.req_v_o      = sel_v;
    assign bus.req_id_o     = sel_id;
    assign bus.req_flag_o   = sel_flag;
    assign bus.req_seq_o    = seq_q[sel_id];
    assign bus.req_ack_o    = ack_q[sel_id];
    assign bus.valid_o      = ~closed_vec;
    assign bus.est_o        = est_vec;

    assign unused_bits = ^{bus.rec_ack_i, bus.rec_flag_i};
endmodule

// File: doc/tcp_conn_table.md
# tcp_conn_table

Parametrised TCP connection table holding `NUM_SOCK` client sockets, each with a full active-open / active-close lifetime FSM plus sequence and acknowledgement tracking. It sits between the RX TCP header parser (which resolves the socket id) and the TX header builder. A round-robin arbiter picks which socket's control packet (SYN, ACK, FIN) is emitted next. It adds multi-socket allocation, the full close path, delayed-ACK generation and a counted TIME_WAIT timeout.

## Interface
Parameters:
- `NUM_SOCK`, default 4: number of socket entries; must be ≥ 2.
- `ID_W`, default `$clog2(NUM_SOCK)`: socket id width.
- `TW_CYCLES`, default 1024: TIME_WAIT duration in clk cycles; must be ≥ 1.

Ports:
- `clk` in 1: clock.
- `nreset` in 1: reset, synchronous, active-low.
- `init_v_i` in 1: allocate a socket.
- `init_seq_i` in 32: initial sequence number (ISN).
- `init_ready_o` out 1: a CLOSED entry exists.
- `init_id_o` out ID_W: id that is allocated if `init_v_i` is asserted this cycle.
- `close_v_i` in 1: request active close.
- `close_id_i` in ID_W: socket to close.
- `cancel_v_i` in 1: abort socket.
- `cancel_id_i` in ID_W: socket to abort.
- `rec_v_i` in 1: valid received header.
- `rec_id_i` in ID_W: socket for the received header.
- `rec_size_i` in 16: payload bytes.
- `rec_seq_i` in 32: received sequence number.
- `rec_ack_i` in 32: received acknowledgement number (unused except in formal checks).
- `rec_flag_i` in 8: received flags.
- `data_v_i` in 1: application data packet sent.
- `data_id_i` in ID_W: socket that sent the data.
- `data_size_i` in 16: payload bytes sent.
- `req_v_o` out 1: a control packet is pending.
- `req_ready_i` in 1: TX accepts the request.
- `req_id_o` out ID_W: socket being requested.
- `req_flag_o` out 8: flags for the request.
- `req_seq_o` out 32: sequence number for the request.
- `req_ack_o` out 32: acknowledgement number for the request.
- `valid_o` out NUM_SOCK: per-socket "not CLOSED".
- `est_o` out NUM_SOCK: per-socket ESTABLISHED.

Flag bit indices: CWR 0, ECE 1, URG 2, ACK 3, PSH 4, RST 5, SYN 6, FIN 7.

## Operation
- Each entry has one-hot states:
  - CLOSED
  - SYN_EMIT
  - SYN_SENT
  - ACK_EMIT
  - ESTABLISHED
  - FIN1_EMIT
  - FIN_WAIT_1
  - FIN_WAIT_2
  - TW_EMIT
  - TIME_WAIT
- Each entry also holds `seq` (32), `ack` (32), `ack_pend` (1) and a TIME_WAIT counter (`$clog2(TW_CYCLES+1)` bits).
- Transitions:
  - CLOSED → SYN_EMIT on `init_v_i & init_ready_o` for the entry at `init_id_o`. This loads `seq = init_seq_i` and `ack = 0`.
  - SYN_EMIT → SYN_SENT on grant. `seq += 1`.
  - SYN_SENT → ACK_EMIT on rec with SYN=1 and ACK=1. `ack = rec_seq_i + 1`.
  - ACK_EMIT → ESTABLISHED on grant.
  - ESTABLISHED → FIN1_EMIT on close.
  - FIN1_EMIT → FIN_WAIT_1 on grant. `seq += 1`.
  - FIN_WAIT_1 → FIN_WAIT_2 on rec with ACK=1.
  - FIN_WAIT_2 → TW_EMIT on rec with FIN=1. `ack = rec_seq_i + rec_size_i + 1`.
  - TW_EMIT → TIME_WAIT on grant. The counter loads `TW_CYCLES`.
  - TIME_WAIT decrements the counter each cycle and goes to CLOSED when the counter is 1.
- ESTABLISHED with rec: `ack += rec_size_i`. `ack_pend` is set if `rec_size_i != 0`.
- ESTABLISHED with `data_v_i`: `seq += data_size_i` and `ack_pend` is cleared, because the data packet carries the ACK. Granting the pending ACK also clears `ack_pend`.
- Events that do not match the entry's current state are ignored. This covers close outside ESTABLISHED, rec or data on a CLOSED entry, and SYN_SENT receiving anything other than SYN+ACK.
- Cancel forces CLOSED in the next cycle and clears `ack_pend`. Cancel has priority over every other event to the same id in the same cycle, including a grant.
- All arithmetic is modulo 2^32; carry-out is discarded. `rec_size_i` and `data_size_i` are zero-extended.
- Allocation:
  - `init_id_o` is the lowest-index CLOSED entry.
  - `init_ready_o = |~valid_o`.
  - `init_v_i` while `init_ready_o` is 0 is dropped.
  - An entry cancelled this cycle is not reusable until the next cycle.
- Request sources per entry: SYN_EMIT, ACK_EMIT, FIN1_EMIT, TW_EMIT, or ESTABLISHED with `ack_pend`.
- Arbitration:
  - Round-robin, starting at the index after the last granted id. The pointer resets to `NUM_SOCK-1`, so the first search starts at 0.
  - Request outputs are held stable until grant, unless cancel removes the selected entry.
- Flags: SYN_EMIT = SYN; ACK_EMIT and ack-pend = ACK; FIN1_EMIT = FIN|ACK; TW_EMIT = ACK.
- `req_seq_o` and `req_ack_o` are the selected entry's current `seq` and `ack`. When `req_v_o` is 0, `req_flag_o` is 0; `req_seq_o` and `req_ack_o` are don't-care.

## Timing
- Reset: all entries CLOSED, all counters 0, `ack_pend` = 0, RR pointer = `NUM_SOCK-1`.
- Output values after reset: `valid_o` = 0, `est_o` = 0, `req_v_o` = 0, `req_flag_o` = 0, `init_ready_o` = 1, `init_id_o` = 0. `seq` and `ack` are unreset.
- Reset asserted mid-operation overrides every input in the same cycle.
- All state, `seq` and `ack` updates take effect in the cycle after the event.
- `req_*` and `init_*` are combinational from registered state only. There is no path from inputs to outputs except `init_ready_o`/`init_id_o`, which depend on state only.
- A grant is `req_v_o & req_ready_i`. A new request can be visible the cycle after a grant; throughput is one grant per cycle.
- Simultaneous rec and data to the same ESTABLISHED id: both updates apply.
- Simultaneous data and ack grant to the same id: `ack_pend` is cleared.
- Simultaneous rec (size > 0) and ack grant to the same id: `ack` advances and `ack_pend` stays set.

## Test plan
- Open: init with ISN 0x0000_0100 → SYN request with seq 0x100; grant; rec SYN|ACK with seq 0x5000 → ACK request with seq 0x101, ack 0x5001; grant → `est_o[0]` = 1.
- Data and wrap: ESTABLISHED with seq 0xFFFF_FFF0; data_size 0x20 → seq 0x10. Rec size 8 → ACK request with ack +8; `data_v_i` in the same cycle as that request → request withdrawn.
- Close: close, FIN|ACK granted, rec ACK, rec FIN with seq S and size 0 → ACK request with ack S+1. Grant → `valid_o` bit drops exactly `TW_CYCLES` cycles later.
- Full and alloc: 4 inits → ids 0,1,2,3 and then `init_ready_o` = 0; a fifth init is ignored. Cancel id 2 → next init gets id 2.
- Arbitration: all 4 entries in SYN_EMIT with `req_ready_i` = 1 → grants in order 0,1,2,3. With id 1 re-requesting → order wraps to 1 after 0.
- Cancel races: cancel id 0 in the same cycle it is granted → CLOSED, no `seq` increment. Reset asserted mid-handshake → all outputs at their reset values the next cycle.
